// File: rtl/fft_pkg.sv
// Shared constants, read-FSM state type and index helper for the FFT frame feeder.
package fft_pkg;

  localparam int N_PTS = 32;
  localparam int IDX_W = 5;
  localparam int DW    = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } rd_state_e;

  // Mirror a 5-bit frame index (bit 0 <-> bit 4, bit 1 <-> bit 3).
  function automatic logic [IDX_W-1:0] bitrev5(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int b = 0; b < IDX_W; b++) begin
      r[b] = idx[IDX_W-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: one write port, one registered read port.
// Address MSB selects the bank, the low bits select the sample in the frame.
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int WIDTH = 2 * DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W:0]   wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [IDX_W:0]   rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [2*N_PTS];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Storage write; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read register only loads while reading, so the output holds between bursts.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Output register with reset so the FFT sees zeros after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers upstream samples into a ping-pong store and replays each complete
// frame to the SDF FFT as one unbroken 32-cycle in_valid burst, with an
// optional idle gap between bursts and optional bit-reversed read order.
// Frame length and sample width are the fixed package constants N_PTS / DW.
module fft_frame_feeder
  import fft_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter int BITREV_OUT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_r,
  input  logic signed [DW-1:0] s_i,
  input  logic                 flush,
  output logic                 in_valid,
  output logic signed [DW-1:0] din_r,
  output logic signed [DW-1:0] din_i,
  output logic                 frame_start,
  output logic [7:0]           frames_sent
);

  localparam int              DATA_W   = 2 * DW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);
  localparam logic [7:0]       GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  rd_state_e        state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             in_valid_q, in_valid_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       frames_sent_q, frames_sent_d;

  logic             flush_eff;
  logic             wr_en;
  logic             wr_last;
  logic             rd_active;
  logic             rd_last;
  logic             gap_done;
  logic [IDX_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // Ready depends only on flops (and rst), never on s_valid.
  assign s_ready   = !rst && !full_q[wr_bank_q];
  // A flush on an empty write bank is a no-op and must not drop a sample.
  assign flush_eff = flush && (wr_idx_q != '0);
  assign wr_en     = s_valid && s_ready && !flush_eff;
  assign wr_last   = wr_en && (wr_idx_q == LAST_IDX);
  assign rd_active = (state_q == BURST);
  assign rd_last   = rd_active && (rd_idx_q == LAST_IDX);
  assign gap_done  = (state_q == GAP) && (gap_cnt_q == GAP_LAST);
  assign rd_addr   = (BITREV_OUT != 0) ? bitrev5(rd_idx_q) : rd_idx_q;

  // Write pointer: advance on accept, toggle bank after the 32nd sample, flush rewinds.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    if (flush_eff) begin
      wr_idx_d = '0;
    end else if (wr_en) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_last) begin
        wr_bank_d = !wr_bank_q;
      end
    end
  end

  // Bank occupancy: a bank cannot be both completed and released on one edge,
  // since writes are blocked on a full bank and reads only release full banks.
  always_comb begin
    full_d = full_q;
    if (rd_last) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  // Read FSM next state. Leaving GAP with a full bank goes straight to BURST so
  // the idle run seen by the FFT is exactly GAP_CYCLES long.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (rd_last) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
          end else if (full_q[!rd_bank_q]) begin
            state_d = BURST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = full_q[rd_bank_q] ? BURST : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read FSM outputs: index/bank/gap counters and the registered FFT strobes,
  // which line up with the registered RAM read one cycle after the address.
  always_comb begin
    rd_idx_d      = rd_idx_q;
    rd_bank_d     = rd_bank_q;
    gap_cnt_d     = gap_cnt_q;
    frames_sent_d = frames_sent_q;
    in_valid_d    = rd_active;
    frame_start_d = rd_active && (rd_idx_q == '0);
    unique case (state_q)
      IDLE: begin
        rd_idx_d  = '0;
        gap_cnt_d = '0;
      end
      BURST: begin
        rd_idx_d = rd_idx_q + 1'b1;
        if (rd_last) begin
          rd_bank_d     = !rd_bank_q;
          frames_sent_d = frames_sent_q + 8'd1;
          gap_cnt_d     = '0;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 8'd1;
      end
      default: begin
        rd_idx_d = '0;
      end
    endcase
  end

  // State register for both write and read sides.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= '0;
      gap_cnt_q     <= '0;
      in_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      gap_cnt_q     <= gap_cnt_d;
      in_valid_q    <= in_valid_d;
      frame_start_q <= frame_start_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  fft_pingpong_ram #(
    .WIDTH(DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .wr_addr ({wr_bank_q, wr_idx_q}),
    .wr_data ({s_r, s_i}),
    .re      (rd_active),
    .rd_addr ({rd_bank_q, rd_addr}),
    .rd_data (rd_data)
  );

  assign in_valid    = in_valid_q;
  assign frame_start = frame_start_q;
  assign frames_sent = frames_sent_q;
  assign din_r       = rd_data[DATA_W-1:DW];
  assign din_i       = rd_data[DW-1:0];

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: three instances (plain, bit-reversed, 5-cycle gap)
// checked every cycle against a frame-schedule model plus literal expectations.
module tb_fft_frame_feeder;

  localparam int ND = 3;

  logic clk;
  logic rst_i [ND];
  logic sv [ND];
  logic fl [ND];
  logic signed [11:0] sr [ND];
  logic signed [11:0] si [ND];
  logic rdy [ND];
  logic iv [ND];
  logic signed [11:0] dr [ND];
  logic signed [11:0] di [ND];
  logic fs [ND];
  logic [7:0] fsent [ND];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    fft_frame_feeder #(
      .GAP_CYCLES((gi == 2) ? 5 : 0),
      .BITREV_OUT((gi == 1) ? 1 : 0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst_i[gi]),
      .s_valid     (sv[gi]),
      .s_ready     (rdy[gi]),
      .s_r         (sr[gi]),
      .s_i         (si[gi]),
      .flush       (fl[gi]),
      .in_valid    (iv[gi]),
      .din_r       (dr[gi]),
      .din_i       (di[gi]),
      .frame_start (fs[gi]),
      .frames_sent (fsent[gi])
    );
  end

  function automatic int gap_of(input int id);
    return (id == 2) ? 5 : 0;
  endfunction

  function automatic int bitrev(input int k);
    return ((k & 1) << 4) | ((k & 2) << 2) | (k & 4) | ((k & 8) >> 2) | ((k & 16) >> 4);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- behavioural model: frames and their burst start edges
  logic signed [11:0] m_r [ND][4][32];
  logic signed [11:0] m_i [ND][4][32];
  logic signed [11:0] part_r [ND][32];
  logic signed [11:0] part_i [ND][32];
  int part_n [ND];
  int n_comp [ND];
  int n_rel [ND];
  int st [ND][4];
  int last_end [ND];
  logic e_valid [ND];
  logic e_fs [ND];
  logic e_rdy [ND];
  logic signed [11:0] e_r [ND];
  logic signed [11:0] e_i [ND];
  logic [7:0] e_sent [ND];
  logic acc [ND];
  int acc_cyc [ND];
  int n_acc [ND];

  // ---------------- monitor for literal expectations
  int run [ND];
  int maxrun [ND];
  int zero_run [ND];
  int last_zero [ND];
  int first_valid [ND];
  int fs_cnt [ND];
  int first_low [ND];
  int seq_n [ND];
  logic signed [11:0] seq_r [ND][128];
  logic signed [11:0] seq_i [ND][128];

  // A frame may start 2 edges after its last sample is accepted, and no sooner
  // than GAP+1 edges after the previous burst's last valid edge.
  task automatic model_step(input int id);
    int slot;
    int idx;
    int f;
    acc[id] = 1'b0;
    if (rst_i[id]) begin
      part_n[id] = 0; n_comp[id] = 0; n_rel[id] = 0; last_end[id] = -1000;
      e_valid[id] = 1'b0; e_fs[id] = 1'b0; e_r[id] = '0; e_i[id] = '0; e_sent[id] = '0;
      return;
    end
    if (fl[id] && part_n[id] != 0) begin
      part_n[id] = 0;
    end else if (sv[id] && (n_comp[id] - n_rel[id] < 2)) begin
      acc[id] = 1'b1;
      acc_cyc[id] = cyc;
      n_acc[id]++;
      part_r[id][part_n[id]] = sr[id];
      part_i[id][part_n[id]] = si[id];
      part_n[id]++;
      if (part_n[id] == 32) begin
        slot = n_comp[id] % 4;
        for (int k = 0; k < 32; k++) begin
          m_r[id][slot][k] = part_r[id][k];
          m_i[id][slot][k] = part_i[id][k];
        end
        st[id][slot] = imax(cyc + 2, last_end[id] + gap_of(id) + 1);
        last_end[id] = st[id][slot] + 31;
        n_comp[id]++;
        part_n[id] = 0;
      end
    end
    e_valid[id] = 1'b0;
    e_fs[id] = 1'b0;
    if (n_comp[id] > n_rel[id]) begin
      slot = n_rel[id] % 4;
      if (cyc >= st[id][slot]) begin
        idx = cyc - st[id][slot];
        f = (id == 1) ? bitrev(idx) : idx;
        e_valid[id] = 1'b1;
        e_r[id] = m_r[id][slot][f];
        e_i[id] = m_i[id][slot][f];
        e_fs[id] = (idx == 0);
        if (idx == 31) begin
          n_rel[id]++;
          e_sent[id] = e_sent[id] + 8'd1;
        end
      end
    end
  endtask

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s dut%0d cyc=%0d actual=%0d required=%0d", name, id, cyc, $signed(act), $signed(exp));
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  // Per-cycle compare: model stepped on the edge, DUT sampled 1 time unit later.
  initial begin : compare
    forever begin
      @(posedge clk);
      cyc++;
      for (int id = 0; id < ND; id++) model_step(id);
      #1;
      for (int id = 0; id < ND; id++) begin
        e_rdy[id] = !rst_i[id] && (n_comp[id] - n_rel[id] < 2);
        cmp("in_valid", id, 32'(iv[id]), 32'(e_valid[id]));
        cmp("din_r", id, 32'(dr[id]), 32'(e_r[id]));
        cmp("din_i", id, 32'(di[id]), 32'(e_i[id]));
        cmp("frame_start", id, 32'(fs[id]), 32'(e_fs[id]));
        cmp("frames_sent", id, 32'(fsent[id]), 32'(e_sent[id]));
        cmp("s_ready", id, 32'(rdy[id]), 32'(e_rdy[id]));
        if (iv[id] === 1'b1) begin
          if (run[id] == 0) begin
            last_zero[id] = zero_run[id];
            if (first_valid[id] < 0) first_valid[id] = cyc;
          end
          run[id]++;
          if (run[id] > maxrun[id]) maxrun[id] = run[id];
          zero_run[id] = 0;
          if (seq_n[id] < 128) begin
            seq_r[id][seq_n[id]] = dr[id];
            seq_i[id][seq_n[id]] = di[id];
            seq_n[id]++;
          end
        end else begin
          run[id] = 0;
          zero_run[id]++;
        end
        if (fs[id] === 1'b1) fs_cnt[id]++;
        if (rdy[id] === 1'b0 && !rst_i[id] && first_low[id] < 0) first_low[id] = n_acc[id];
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  task automatic clr_mon(input int id);
    run[id] = 0; maxrun[id] = 0; zero_run[id] = 0; last_zero[id] = -1;
    first_valid[id] = -1; fs_cnt[id] = 0; first_low[id] = -1; seq_n[id] = 0; n_acc[id] = 0;
  endtask

  task automatic push(input int id, input int r, input int i);
    int guard;
    guard = 0;
    sv[id] = 1'b1;
    sr[id] = 12'(r);
    si[id] = 12'(i);
    do begin
      @(negedge clk);
      guard++;
    end while (!acc[id] && guard < 500);
    if (!acc[id]) begin
      checks++;
      failures++;
      $display("FAIL push_timeout dut%0d sample=%0d actual=not_accepted required=accepted", id, r);
    end
  endtask

  task automatic idle(input int id);
    sv[id] = 1'b0;
  endtask

  task automatic do_reset(input int id);
    rst_i[id] = 1'b1;
    @(negedge clk);
    rst_i[id] = 1'b0;
  endtask

  task automatic do_flush(input int id);
    sv[id] = 1'b0;
    fl[id] = 1'b1;
    @(negedge clk);
    fl[id] = 1'b0;
  endtask

  initial begin : stim
    int t;
    for (int id = 0; id < ND; id++) begin
      rst_i[id] = 1'b1; sv[id] = 1'b0; fl[id] = 1'b0; sr[id] = '0; si[id] = '0;
      part_n[id] = 0; n_comp[id] = 0; n_rel[id] = 0; last_end[id] = -1000;
      e_sent[id] = '0; acc[id] = 1'b0; acc_cyc[id] = 0;
      clr_mon(id);
    end
    repeat (3) @(negedge clk);
    for (int id = 0; id < ND; id++) rst_i[id] = 1'b0;
    @(negedge clk);
    chk("reset_frames_sent", int'(fsent[0]), 0);
    chk("reset_in_valid", int'(iv[0]), 0);
    chk("reset_s_ready_after", int'(rdy[0]), 1);

    // T1: one frame, natural order
    clr_mon(0);
    for (int k = 0; k < 32; k++) push(0, k, -k);
    idle(0);
    repeat (40) @(negedge clk);
    chk("t1_latency", first_valid[0] - acc_cyc[0], 2);
    chk("t1_run", maxrun[0], 32);
    chk("t1_frame_start_cnt", fs_cnt[0], 1);
    chk("t1_frames_sent", int'(fsent[0]), 1);
    chk("t1_first_r", int'(seq_r[0][0]), 0);
    chk("t1_last_r", int'(seq_r[0][31]), 31);
    chk("t1_last_i", int'(seq_i[0][31]), -31);

    // T2: bit-reversed instance
    clr_mon(1);
    for (int k = 0; k < 32; k++) push(1, k, -k);
    idle(1);
    repeat (40) @(negedge clk);
    chk("t2_r0", int'(seq_r[1][0]), 0);
    chk("t2_r1", int'(seq_r[1][1]), 16);
    chk("t2_r2", int'(seq_r[1][2]), 8);
    chk("t2_r3", int'(seq_r[1][3]), 24);
    chk("t2_r4", int'(seq_r[1][4]), 4);
    chk("t2_r31", int'(seq_r[1][31]), 31);

    // T3: 96 samples back-to-back, zero gap
    do_reset(0);
    clr_mon(0);
    for (int k = 0; k < 96; k++) push(0, k, 500 - k);
    idle(0);
    repeat (120) @(negedge clk);
    chk("t3_ready_drop_after", first_low[0], 64);
    chk("t3_max_run", maxrun[0], 64);
    chk("t3_frames_sent", int'(fsent[0]), 3);
    chk("t3_samples_out", seq_n[0], 96);

    // T4: 64 samples with a 5-cycle gap
    clr_mon(2);
    for (int k = 0; k < 64; k++) push(2, k + 7, -k);
    idle(2);
    repeat (100) @(negedge clk);
    chk("t4_gap", last_zero[2], 5);
    chk("t4_max_run", maxrun[2], 32);
    chk("t4_frames_sent", int'(fsent[2]), 2);

    // T5: partial frame flushed, then a full frame
    do_reset(0);
    clr_mon(0);
    for (int k = 0; k < 10; k++) push(0, 50 + k, k);
    do_flush(0);
    for (int k = 0; k < 32; k++) push(0, 100 + k, -(100 + k));
    idle(0);
    repeat (40) @(negedge clk);
    chk("t5_frames_sent", int'(fsent[0]), 1);
    chk("t5_samples_out", seq_n[0], 32);
    chk("t5_first_r", int'(seq_r[0][0]), 100);
    chk("t5_last_r", int'(seq_r[0][31]), 131);

    // T6: reset on the 12th burst cycle, then a clean frame
    do_reset(0);
    clr_mon(0);
    for (int k = 0; k < 32; k++) push(0, 300 + k, k);
    idle(0);
    t = 0;
    while (run[0] != 12 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t6_reached_cycle12", run[0], 12);
    rst_i[0] = 1'b1;
    @(posedge clk);
    #2;
    chk("t6_rst_in_valid", int'(iv[0]), 0);
    chk("t6_rst_frames_sent", int'(fsent[0]), 0);
    chk("t6_rst_s_ready", int'(rdy[0]), 0);
    @(negedge clk);
    rst_i[0] = 1'b0;
    clr_mon(0);
    for (int k = 0; k < 32; k++) push(0, 200 + k, -k);
    idle(0);
    repeat (40) @(negedge clk);
    chk("t6_run", maxrun[0], 32);
    chk("t6_frames_sent", int'(fsent[0]), 1);
    chk("t6_first_r", int'(seq_r[0][0]), 200);
    chk("t6_last_r", int'(seq_r[0][31]), 231);
    chk("t6_samples_out", seq_n[0], 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
